// File: rtl/op_lut_ioq_hdr_rewriter.sv
// rtl/op_lut_ioq_hdr_rewriter.sv - IOQ header DST_PORT rewriter fed by the op_lut parser result FIFO (option: OP_LUT_REWRITE_PKT_CNT_EN)

`ifndef IO_QUEUE_STAGE_NUM
`define IO_QUEUE_STAGE_NUM 8'hff
`endif

`ifndef IOQ_DST_PORT_POS
`define IOQ_DST_PORT_POS 0
`endif

// Small fall-through FIFO: head word is visible on dout while not empty.
module op_lut_ioq_hdr_rewriter_pkt_fifo #(
    parameter int WIDTH      = 72,
    parameter int DEPTH_BITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic             nearly_full
);
    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] LVL_FULL   = (DEPTH_BITS+1)'(DEPTH);
    localparam logic [DEPTH_BITS:0] LVL_NEARLY = (DEPTH_BITS+1)'(DEPTH - 1);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic [DEPTH_BITS:0]   count;
    logic                  do_wr;
    logic                  do_rd;

    assign do_wr       = wr_en && !full;
    assign do_rd       = rd_en && !empty;
    assign dout        = mem[rd_ptr];
    assign empty       = (count == '0);
    assign full        = (count == LVL_FULL);
    assign nearly_full = (count >= LVL_NEARLY);

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; reset flushes the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            if (do_wr && !do_rd)      count <= count + 1'b1;
            else if (!do_wr && do_rd) count <= count - 1'b1;
        end
    end
endmodule

module op_lut_ioq_hdr_rewriter #(
    parameter int                          DATA_WIDTH          = 64,
    parameter int                          CTRL_WIDTH          = DATA_WIDTH / 8,
    parameter int                          NUM_QUEUES          = 8,
    parameter int                          NUM_QUEUES_WIDTH    = $clog2(NUM_QUEUES),
    parameter logic [CTRL_WIDTH-1:0]       IO_QUEUE_STAGE_NUM  = `IO_QUEUE_STAGE_NUM,
    parameter int                          PKT_FIFO_DEPTH_BITS = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic [CTRL_WIDTH-1:0]       in_ctrl,
    input  logic                        in_wr,
    output logic                        in_rdy,
    input  logic                        is_from_cpu,
    input  logic [NUM_QUEUES-1:0]       to_cpu_output_port,
    input  logic [NUM_QUEUES-1:0]       from_cpu_output_port,
    input  logic [NUM_QUEUES_WIDTH-1:0] input_port_num,
    input  logic                        is_from_cpu_vld,
    output logic                        rd_hdr_parser,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic [CTRL_WIDTH-1:0]       out_ctrl,
    output logic                        out_wr,
    input  logic                        out_rdy
`ifdef OP_LUT_REWRITE_PKT_CNT_EN
    ,
    output logic [31:0]                 num_pkts_from_cpu,
    output logic [31:0]                 num_pkts_to_cpu
`endif
);
    localparam int DST_POS = `IOQ_DST_PORT_POS;

    typedef enum logic [0:0] {
        WAIT_HDR = 1'b0,
        WAIT_EOP = 1'b1
    } state_t;

    state_t                           state;
    logic [DATA_WIDTH-1:0]            fifo_data;
    logic [CTRL_WIDTH-1:0]            fifo_ctrl;
    logic                             fifo_empty;
    logic                             fifo_full;
    logic                             fifo_nearly_full;
    logic                             hdr_slot;
    logic                             advance;
    logic [15:0]                      dst_port;
    logic [DATA_WIDTH-1:0]            rewritten;

    // The source port number is carried by the parser but not needed here.
    logic unused_input_port_num;
    assign unused_input_port_num = ^{1'b0, input_port_num, fifo_full};

    op_lut_ioq_hdr_rewriter_pkt_fifo #(
        .WIDTH      (DATA_WIDTH + CTRL_WIDTH),
        .DEPTH_BITS (PKT_FIFO_DEPTH_BITS)
    ) u_pkt_fifo (
        .clk         (clk),
        .reset       (reset),
        .din         ({in_ctrl, in_data}),
        .wr_en       (in_wr),
        .rd_en       (advance),
        .dout        ({fifo_ctrl, fifo_data}),
        .empty       (fifo_empty),
        .full        (fifo_full),
        .nearly_full (fifo_nearly_full)
    );

    assign in_rdy = !fifo_nearly_full;

    // An IOQ header may only leave together with its parser result, keeping both FIFOs in lockstep.
    assign hdr_slot      = (state == WAIT_HDR) && (fifo_ctrl == IO_QUEUE_STAGE_NUM);
    assign advance       = !reset && !fifo_empty && out_rdy && (!hdr_slot || is_from_cpu_vld);
    assign rd_hdr_parser = advance && hdr_slot;

    // CPU-sourced packets go to their MAC port, everything else to its CPU port.
    always_comb begin
        dst_port = '0;
        dst_port[NUM_QUEUES-1:0] = is_from_cpu ? from_cpu_output_port : to_cpu_output_port;
        rewritten = fifo_data;
        rewritten[DST_POS +: 16] = dst_port;
    end

    // Packet framing FSM with registered output word; out_* hold when nothing advances.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= WAIT_HDR;
            out_wr   <= 1'b0;
            out_data <= '0;
            out_ctrl <= '0;
        end else begin
            out_wr <= advance;
            if (advance) begin
                out_data <= hdr_slot ? rewritten : fifo_data;
                out_ctrl <= fifo_ctrl;
                case (state)
                    WAIT_HDR: if (fifo_ctrl == '0) state <= WAIT_EOP;
                    WAIT_EOP: if (fifo_ctrl != '0) state <= WAIT_HDR;
                    default:  state <= WAIT_HDR;
                endcase
            end
        end
    end

`ifdef OP_LUT_REWRITE_PKT_CNT_EN
    // Per-direction packet counters, one count per consumed parser result.
    always_ff @(posedge clk) begin
        if (reset) begin
            num_pkts_from_cpu <= '0;
            num_pkts_to_cpu   <= '0;
        end else if (rd_hdr_parser) begin
            if (is_from_cpu) num_pkts_from_cpu <= num_pkts_from_cpu + 32'd1;
            else             num_pkts_to_cpu   <= num_pkts_to_cpu + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_op_lut_ioq_hdr_rewriter.sv
// tb/tb_op_lut_ioq_hdr_rewriter.sv - scoreboard bench for op_lut_ioq_hdr_rewriter
module tb_op_lut_ioq_hdr_rewriter;
    localparam logic [7:0] IOQ = 8'hff;

    typedef struct packed {
        logic       cpu;
        logic [7:0] to_cpu;
        logic [7:0] from_cpu;
        logic [2:0] src;
    } res_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic        in_rdy;
    logic        is_from_cpu;
    logic [7:0]  to_cpu_output_port;
    logic [7:0]  from_cpu_output_port;
    logic [2:0]  input_port_num;
    logic        is_from_cpu_vld;
    logic        rd_hdr_parser;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy;
`ifdef OP_LUT_REWRITE_PKT_CNT_EN
    logic [31:0] num_pkts_from_cpu;
    logic [31:0] num_pkts_to_cpu;
`endif

    op_lut_ioq_hdr_rewriter dut (
        .clk                  (clk),
        .reset                (reset),
        .in_data              (in_data),
        .in_ctrl              (in_ctrl),
        .in_wr                (in_wr),
        .in_rdy               (in_rdy),
        .is_from_cpu          (is_from_cpu),
        .to_cpu_output_port   (to_cpu_output_port),
        .from_cpu_output_port (from_cpu_output_port),
        .input_port_num       (input_port_num),
        .is_from_cpu_vld      (is_from_cpu_vld),
        .rd_hdr_parser        (rd_hdr_parser),
        .out_data             (out_data),
        .out_ctrl             (out_ctrl),
        .out_wr               (out_wr),
        .out_rdy              (out_rdy)
`ifdef OP_LUT_REWRITE_PKT_CNT_EN
        ,
        .num_pkts_from_cpu    (num_pkts_from_cpu),
        .num_pkts_to_cpu      (num_pkts_to_cpu)
`endif
    );

    always #5 clk = ~clk;

    res_t        res_q[$];
    logic [71:0] tx_q[$];
    logic [71:0] exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          out_cnt = 0;
    int          pop_cnt = 0;
    bit          vld_en = 1'b1;
    bit          toggle = 1'b0;
    logic        last_out_wr;
    logic        last_rd;
    logic [7:0]  last_ctrl;
    int          o0;
    int          p0;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_parser();
        if (vld_en && res_q.size() > 0) begin
            is_from_cpu_vld = 1'b1;
            {is_from_cpu, to_cpu_output_port, from_cpu_output_port, input_port_num} = res_q[0];
        end else begin
            is_from_cpu_vld = 1'b0;
        end
    endtask

    task automatic drive_in();
        if (tx_q.size() > 0 && in_rdy) begin
            in_wr = 1'b1;
            {in_ctrl, in_data} = tx_q[0];
        end else begin
            in_wr = 1'b0;
        end
    endtask

    // One clock: observe at negedge, apply queue effects and new drives just after posedge.
    task automatic tick();
        logic        wr_acc;
        logic        pop_pend;
        logic [71:0] e;
        @(negedge clk);
        last_out_wr = out_wr;
        last_rd     = rd_hdr_parser;
        last_ctrl   = out_ctrl;
        wr_acc      = in_wr;
        pop_pend    = rd_hdr_parser;
        if (out_wr) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
                check("out_wr_unexpected", {71'h0, out_wr}, 72'h0);
            end else begin
                e = exp_q.pop_front();
                check("out_word", {out_ctrl, out_data}, e);
            end
        end
        if (rd_hdr_parser) pop_cnt++;
        @(posedge clk);
        #1;
        if (wr_acc && tx_q.size() > 0) void'(tx_q.pop_front());
        if (pop_pend && res_q.size() > 0) void'(res_q.pop_front());
        if (toggle) out_rdy = ~out_rdy;
        drive_parser();
        drive_in();
    endtask

    task automatic load_pkt(input int n, input bit hdr, input res_t r);
        logic [7:0]  c;
        logic [71:0] w;
        for (int i = 0; i < n; i++) begin
            if (i == 0)          c = hdr ? IOQ : 8'h20;
            else if (i == n - 1) c = 8'h80;
            else                 c = 8'h00;
            w = {c, $urandom, $urandom};
            tx_q.push_back(w);
            if (i == 0 && hdr) w[15:0] = {8'h00, r.cpu ? r.from_cpu : r.to_cpu};
            exp_q.push_back(w);
        end
        drive_in();
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while ((exp_q.size() > 0 || tx_q.size() > 0) && k < 300) begin
            tick();
            k++;
        end
        check({tag, "_timeout"}, {71'h0, exp_q.size() == 0}, 72'h1);
        repeat (3) tick();
    endtask

    initial begin
        reset = 1'b1;
        in_wr = 1'b0;
        in_data = '0;
        in_ctrl = '0;
        is_from_cpu = 1'b0;
        to_cpu_output_port = '0;
        from_cpu_output_port = '0;
        input_port_num = '0;
        is_from_cpu_vld = 1'b0;
        out_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_wr",   {71'h0, out_wr}, 72'h0);
        check("rst_out_data", {8'h0, out_data}, 72'h0);
        check("rst_out_ctrl", {64'h0, out_ctrl}, 72'h0);
        check("rst_rd_hdr",   {71'h0, rd_hdr_parser}, 72'h0);
        check("rst_in_rdy",   {71'h0, in_rdy}, 72'h1);
        @(posedge clk);
        #1;

        // CPU-sourced packet: header + 3 data words
        o0 = out_cnt; p0 = pop_cnt;
        res_q.push_back('{cpu: 1'b1, to_cpu: 8'h02, from_cpu: 8'h01, src: 3'd1});
        drive_parser();
        load_pkt(4, 1'b1, res_q[0]);
        drain("t1");
        check("t1_out_cnt", 72'(out_cnt - o0), 72'd4);
        check("t1_pops",    72'(pop_cnt - p0), 72'd1);
`ifdef OP_LUT_REWRITE_PKT_CNT_EN
        check("t1_cnt_from", {40'h0, num_pkts_from_cpu}, 72'd1);
`endif

        // MAC-sourced packet from port 2 goes to CPU port 0x08
        o0 = out_cnt; p0 = pop_cnt;
        res_q.push_back('{cpu: 1'b0, to_cpu: 8'h08, from_cpu: 8'h04, src: 3'd2});
        drive_parser();
        load_pkt(4, 1'b1, res_q[0]);
        drain("t2");
        check("t2_out_cnt", 72'(out_cnt - o0), 72'd4);
        check("t2_pops",    72'(pop_cnt - p0), 72'd1);
`ifdef OP_LUT_REWRITE_PKT_CNT_EN
        check("t2_cnt_to", {40'h0, num_pkts_to_cpu}, 72'd1);
`endif

        // Header stalls while the parser result is missing
        o0 = out_cnt; p0 = pop_cnt;
        vld_en = 1'b0;
        res_q.push_back('{cpu: 1'b1, to_cpu: 8'h02, from_cpu: 8'h04, src: 3'd3});
        drive_parser();
        load_pkt(4, 1'b1, res_q[0]);
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_out_wr", {71'h0, last_out_wr}, 72'h0);
            check("stall_rd_hdr", {71'h0, last_rd}, 72'h0);
        end
        vld_en = 1'b1;
        drive_parser();
        tick();
        check("unstall_rd_hdr", {71'h0, last_rd}, 72'h1);
        tick();
        check("unstall_out_wr", {71'h0, last_out_wr}, 72'h1);
        check("unstall_ctrl",   {64'h0, last_ctrl}, {64'h0, IOQ});
        drain("t3");
        check("t3_pops", 72'(pop_cnt - p0), 72'd1);

        // out_rdy toggling every cycle across a 10-word packet
        o0 = out_cnt; p0 = pop_cnt;
        res_q.push_back('{cpu: 1'b0, to_cpu: 8'h80, from_cpu: 8'h40, src: 3'd6});
        drive_parser();
        toggle = 1'b1;
        load_pkt(10, 1'b1, res_q[0]);
        drain("t4");
        toggle = 1'b0;
        out_rdy = 1'b1;
        check("t4_out_cnt", 72'(out_cnt - o0), 72'd10);
        check("t4_pops",    72'(pop_cnt - p0), 72'd1);

        // Header-less packet must not consume the queued result
        o0 = out_cnt; p0 = pop_cnt;
        res_q.push_back('{cpu: 1'b1, to_cpu: 8'h02, from_cpu: 8'h10, src: 3'd5});
        drive_parser();
        load_pkt(5, 1'b0, res_q[0]);
        load_pkt(4, 1'b1, res_q[0]);
        drain("t5");
        check("t5_out_cnt", 72'(out_cnt - o0), 72'd9);
        check("t5_pops",    72'(pop_cnt - p0), 72'd1);
        check("t5_res_left", 72'(res_q.size()), 72'd0);

        // Reset in the middle of a packet
        res_q.push_back('{cpu: 1'b0, to_cpu: 8'h20, from_cpu: 8'h10, src: 3'd4});
        drive_parser();
        load_pkt(8, 1'b1, res_q[0]);
        repeat (4) tick();
        reset = 1'b1;
        tx_q.delete();
        drive_in();
        tick();
        exp_q.delete();
        res_q.delete();
        drive_parser();
        reset = 1'b0;
        tick();
        check("midrst_out_wr", {71'h0, last_out_wr}, 72'h0);
        check("midrst_in_rdy", {71'h0, in_rdy}, 72'h1);
        check("midrst_out_data", {8'h0, out_data}, 72'h0);
        o0 = out_cnt; p0 = pop_cnt;
        res_q.push_back('{cpu: 1'b0, to_cpu: 8'h02, from_cpu: 8'h01, src: 3'd0});
        drive_parser();
        load_pkt(4, 1'b1, res_q[0]);
        drain("t6");
        check("t6_out_cnt", 72'(out_cnt - o0), 72'd4);
        check("t6_pops",    72'(pop_cnt - p0), 72'd1);
`ifdef OP_LUT_REWRITE_PKT_CNT_EN
        check("t6_cnt_to",   {40'h0, num_pkts_to_cpu}, 72'd1);
        check("t6_cnt_from", {40'h0, num_pkts_from_cpu}, 72'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
